// File: rtl/mcu_job_scheduler.sv
// rtl/mcu_job_scheduler.sv - descriptor queue and issue FSM in front of the MCU global FSM port
// Queues run descriptors, issues them one at a time and returns one status record per job.
module mcu_job_scheduler #(
  parameter int DATA_ADDR      = 32,
  parameter int GRID_ADDR      = 32,
  parameter int SCALE_ADDR     = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ABORT_ON_ERROR = 1
) (
  input  logic                           fsm_clk,
  input  logic                           rst,
  input  logic [DATA_ADDR:0]             s_job_data_size,
  input  logic [GRID_ADDR:0]             s_job_grid_size,
  input  logic [SCALE_ADDR:0]            s_job_scle_size,
  input  logic [TAG_WIDTH-1:0]           s_job_tag,
  input  logic                           s_job_valid,
  output logic                           s_job_ready,
  input  logic                           flush,
  output logic                           operation_start,
  output logic [DATA_ADDR:0]             data_size,
  output logic [GRID_ADDR:0]             grid_size,
  output logic [SCALE_ADDR:0]            scle_size,
  input  logic                           operation_busy,
  input  logic                           operation_complete,
  input  logic                           operation_error,
  output logic [TAG_WIDTH-1:0]           m_status_tag,
  output logic [1:0]                     m_status_code,
  output logic                           m_status_valid,
  input  logic                           m_status_ready,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic                           sched_busy,
  output logic                           halted
);

  localparam int LW = $clog2(QUEUE_DEPTH);
  localparam int EW = DATA_ADDR + GRID_ADDR + SCALE_ADDR + 3 + TAG_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] CODE_OK = 2'b00, CODE_ERR = 2'b01, CODE_TMO = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_RUN, S_REPORT, S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [QUEUE_DEPTH];
  logic [LW-1:0]   wr_ptr, rd_ptr;
  logic [LW:0]     count;
  logic [TW-1:0]   tmo_cnt;
  logic            full, push, pop, tmo_hit, code_load;
  logic [1:0]      code_nxt;

  assign full        = (count == (LW+1)'(QUEUE_DEPTH));
  assign halted      = (state == S_HALT);
  assign s_job_ready = !full && !flush && !halted;
  assign push        = s_job_valid && s_job_ready;
  assign pop         = (state == S_IDLE) && (count != '0) && !flush;
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  assign m_status_valid = (state == S_REPORT);
  assign sched_busy     = (state != S_IDLE);
  assign queue_level    = count;

  always_ff @(posedge fsm_clk) begin
    if (push) mem[wr_ptr] <= {s_job_data_size, s_job_grid_size, s_job_scle_size, s_job_tag};
  end

  // Flush realigns the read pointer; push is already blocked while flush is high.
  always_ff @(posedge fsm_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = CODE_OK;
    code_load = 1'b0;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT_ACK;
      S_WAIT_ACK, S_RUN: begin
        // Error beats complete beats timeout; done signals are honoured even before busy.
        if (operation_error) begin
          state_nxt = S_REPORT;
          code_nxt  = CODE_ERR;
          code_load = 1'b1;
        end else if (operation_complete) begin
          state_nxt = S_REPORT;
          code_nxt  = CODE_OK;
          code_load = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = S_REPORT;
          code_nxt  = CODE_TMO;
          code_load = 1'b1;
        end else if (state == S_WAIT_ACK && operation_busy) begin
          state_nxt = S_RUN;
        end
      end
      S_REPORT: if (m_status_ready)
        state_nxt = (m_status_code != CODE_OK && ABORT_ON_ERROR != 0) ? S_HALT : S_IDLE;
      S_HALT:  if (flush) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fsm_clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      operation_start <= 1'b0;
      tmo_cnt         <= '0;
      data_size       <= '0;
      grid_size       <= '0;
      scle_size       <= '0;
      m_status_tag    <= '0;
      m_status_code   <= '0;
    end else begin
      state           <= state_nxt;
      operation_start <= (state == S_ISSUE);
      if (state == S_ISSUE)
        tmo_cnt <= '0;
      else if ((state == S_WAIT_ACK || state == S_RUN) && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (pop) {data_size, grid_size, scle_size, m_status_tag} <= mem[rd_ptr];
      if (code_load) m_status_code <= code_nxt;
    end
  end

endmodule

// File: tb/tb_mcu_job_scheduler.sv
// tb/tb_mcu_job_scheduler.sv - directed self-checking bench for mcu_job_scheduler
// Main instance uses a long timeout; a second instance with TIMEOUT_CYCLES=8 covers the timeout path.
module tb_mcu_job_scheduler;

  logic        fsm_clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] s_job_data_size, s_job_grid_size, s_job_scle_size;
  logic [7:0]  s_job_tag;
  logic        s_job_valid, s_job_ready, flush, operation_start;
  logic [32:0] data_size, grid_size, scle_size;
  logic        operation_busy, operation_complete, operation_error;
  logic [7:0]  m_status_tag;
  logic [1:0]  m_status_code;
  logic        m_status_valid, m_status_ready;
  logic [2:0]  queue_level;
  logic        sched_busy, halted;

  logic        t_valid, t_ready, t_flush, t_start, t_status_valid, t_sched_busy, t_halted;
  logic [32:0] t_data_size, t_grid_size, t_scle_size;
  logic [7:0]  t_status_tag;
  logic [1:0]  t_status_code;
  logic [2:0]  t_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 fsm_clk = ~fsm_clk;

  mcu_job_scheduler #(.TIMEOUT_CYCLES(64)) dut (
    .fsm_clk(fsm_clk), .rst(rst),
    .s_job_data_size(s_job_data_size), .s_job_grid_size(s_job_grid_size),
    .s_job_scle_size(s_job_scle_size), .s_job_tag(s_job_tag),
    .s_job_valid(s_job_valid), .s_job_ready(s_job_ready), .flush(flush),
    .operation_start(operation_start), .data_size(data_size), .grid_size(grid_size),
    .scle_size(scle_size), .operation_busy(operation_busy),
    .operation_complete(operation_complete), .operation_error(operation_error),
    .m_status_tag(m_status_tag), .m_status_code(m_status_code),
    .m_status_valid(m_status_valid), .m_status_ready(m_status_ready),
    .queue_level(queue_level), .sched_busy(sched_busy), .halted(halted)
  );

  mcu_job_scheduler #(.TIMEOUT_CYCLES(8)) dut_t (
    .fsm_clk(fsm_clk), .rst(rst),
    .s_job_data_size(33'd7), .s_job_grid_size(33'd3), .s_job_scle_size(33'd2),
    .s_job_tag(8'hC3), .s_job_valid(t_valid), .s_job_ready(t_ready), .flush(t_flush),
    .operation_start(t_start), .data_size(t_data_size), .grid_size(t_grid_size),
    .scle_size(t_scle_size), .operation_busy(1'b0), .operation_complete(1'b0),
    .operation_error(1'b0), .m_status_tag(t_status_tag), .m_status_code(t_status_code),
    .m_status_valid(t_status_valid), .m_status_ready(1'b1), .queue_level(t_level),
    .sched_busy(t_sched_busy), .halted(t_halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic push(input int d, input int g, input int s, input logic [7:0] tg);
    s_job_data_size = 33'(d);
    s_job_grid_size = 33'(g);
    s_job_scle_size = 33'(s);
    s_job_tag       = tg;
    s_job_valid     = 1'b1;
    tick();
    s_job_valid     = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!operation_start && n < 60) begin
      tick();
      n++;
    end
    check("start_seen", 64'(operation_start), 64'd1);
  endtask

  task automatic mcu_done(input logic c, input logic e);
    operation_busy     = 1'b0;
    operation_complete = c;
    operation_error    = e;
    tick();
    operation_complete = 1'b0;
    operation_error    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt, bad;
    s_job_data_size = '0; s_job_grid_size = '0; s_job_scle_size = '0; s_job_tag = '0;
    s_job_valid = 0; flush = 0; operation_busy = 0; operation_complete = 0;
    operation_error = 0; m_status_ready = 1; t_valid = 0; t_flush = 0;

    // reset values
    #2;
    check("rst_ready", 64'(s_job_ready), 64'd1);
    check("rst_level", 64'(queue_level), 64'd0);
    check("rst_busy", 64'(sched_busy), 64'd0);
    check("rst_start", 64'(operation_start), 64'd0);
    check("rst_valid", 64'(m_status_valid), 64'd0);
    check("rst_t_halted", 64'(t_halted), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single job
    push(100, 16, 1, 8'h5A);
    check("t1_level1", 64'(queue_level), 64'd1);
    tick();
    check("t1_level0", 64'(queue_level), 64'd0);
    check("t1_busy", 64'(sched_busy), 64'd1);
    check("t1_nostart", 64'(operation_start), 64'd0);
    tick();
    check("t1_start", 64'(operation_start), 64'd1);
    check("t1_data", 64'(data_size), 64'd100);
    check("t1_grid", 64'(grid_size), 64'd16);
    check("t1_scle", 64'(scle_size), 64'd1);
    tick();
    check("t1_start_once", 64'(operation_start), 64'd0);
    operation_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      cnt += int'(operation_start);
    end
    mcu_done(1'b1, 1'b0);
    check("t1_extra_start", 64'(cnt), 64'd0);
    check("t1_valid", 64'(m_status_valid), 64'd1);
    check("t1_tag", 64'(m_status_tag), 64'h5A);
    check("t1_code", 64'(m_status_code), 64'd0);
    tick();
    check("t1_valid_drop", 64'(m_status_valid), 64'd0);
    check("t1_idle", 64'(sched_busy), 64'd0);

    // queue full then back-to-back in tag order
    for (int t = 1; t <= 5; t++) push(t * 10, t, 1, 8'(t));
    check("full_level", 64'(queue_level), 64'd4);
    check("full_ready", 64'(s_job_ready), 64'd0);
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) begin
        wait_start(n);
        check("b2b_lat", 64'(n), 64'd2);
        check("b2b_data", 64'(data_size), 64'(t * 10));
      end
      mcu_done(1'b1, 1'b0);
      check("b2b_valid", 64'(m_status_valid), 64'd1);
      check("b2b_tag", 64'(m_status_tag), 64'(t));
      check("b2b_code", 64'(m_status_code), 64'd0);
      tick();
    end
    check("b2b_idle", 64'(sched_busy), 64'd0);

    // error abort with complete and error together
    push(1, 1, 1, 8'h11);
    push(2, 1, 1, 8'h12);
    push(3, 1, 1, 8'h13);
    wait_start(n);
    mcu_done(1'b1, 1'b1);
    check("err_tag", 64'(m_status_tag), 64'h11);
    check("err_code", 64'(m_status_code), 64'd1);
    tick();
    check("err_halted", 64'(halted), 64'd1);
    check("err_ready", 64'(s_job_ready), 64'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(operation_start);
    end
    check("err_no_start", 64'(cnt), 64'd0);
    check("err_level", 64'(queue_level), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", 64'(queue_level), 64'd0);
    check("flush_halted", 64'(halted), 64'd0);
    check("flush_idle", 64'(sched_busy), 64'd0);

    // status backpressure
    m_status_ready = 1'b0;
    push(33, 1, 1, 8'h21);
    push(34, 1, 1, 8'h22);
    wait_start(n);
    mcu_done(1'b1, 1'b0);
    check("bp_tag", 64'(m_status_tag), 64'h21);
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_status_tag !== 8'h21 || m_status_code !== 2'b00 || m_status_valid !== 1'b1) bad++;
      cnt += int'(operation_start);
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_no_start", 64'(cnt), 64'd0);
    m_status_ready = 1'b1;
    tick();
    wait_start(n);
    check("bp_lat", 64'(n), 64'd2);
    check("bp_data", 64'(data_size), 64'd34);
    mcu_done(1'b1, 1'b0);
    tick();

    // timeout on the short-timeout instance
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    n = 0;
    while (!t_start && n < 20) begin
      tick();
      n++;
    end
    check("tmo_start", 64'(t_start), 64'd1);
    n = 0;
    while (!t_status_valid && n < 40) begin
      tick();
      n++;
    end
    check("tmo_cycles", 64'(n), 64'd8);
    check("tmo_code", 64'(t_status_code), 64'd2);
    check("tmo_tag", 64'(t_status_tag), 64'hC3);
    tick();
    check("tmo_halted", 64'(t_halted), 64'd1);
    t_flush = 1'b1;
    tick();
    t_flush = 1'b0;
    check("tmo_unhalt", 64'(t_halted), 64'd0);

    // reset in the middle of a run
    push(41, 1, 1, 8'h31);
    push(42, 1, 1, 8'h32);
    push(43, 1, 1, 8'h33);
    wait_start(n);
    operation_busy = 1'b1;
    tick();
    check("mr_level", 64'(queue_level), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("mr_busy", 64'(sched_busy), 64'd0);
    check("mr_level0", 64'(queue_level), 64'd0);
    check("mr_data", 64'(data_size), 64'd0);
    check("mr_tag", 64'(m_status_tag), 64'd0);
    check("mr_ready", 64'(s_job_ready), 64'd1);
    operation_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(m_status_valid) + int'(operation_start);
    end
    check("mr_no_status", 64'(cnt), 64'd0);
    check("mr_idle", 64'(sched_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
